// File: rtl/mem_wb_writeback_pkg.sv
// ----------------------------------------------------------------------------
// mem_wb_writeback_pkg
//
// Shared definitions for the MEM/WB write-back slice:
//   - default register index width and the link register index
//   - the hard-wired zero register index
//   - encoding of the write-back data source (ALU / MEM / PC)
// ----------------------------------------------------------------------------
package mem_wb_writeback_pkg;

    localparam int DefRegAddrBits = 5;
    localparam int DefLinkReg     = 31;
    localparam int ZeroReg        = 0;

    typedef enum logic [1:0] {
        SrcAlu = 2'd0,
        SrcMem = 2'd1,
        SrcPc  = 2'd2
    } wbSrc_e;

endpackage : mem_wb_writeback_pkg

// File: rtl/mem_wb_writeback_wb_source_mux.sv
// ----------------------------------------------------------------------------
// wb_source_mux
//
// Three-way write-back data select driven by the encoded source.
//
// Ports:
//   sel        in   wbSrc_e   selected source (ALU, MEM or PC)
//   aluResult  in   NBits     ALU result
//   memData    in   NBits     load data
//   pcPlus4    in   NBits     return address for link instructions
//   writeData  out  NBits     selected write-back data
// ----------------------------------------------------------------------------
import mem_wb_writeback_pkg::*;

module wb_source_mux #(
    parameter int NBits = 32
) (
    input  wbSrc_e           sel,
    input  logic [NBits-1:0] aluResult,
    input  logic [NBits-1:0] memData,
    input  logic [NBits-1:0] pcPlus4,
    output logic [NBits-1:0] writeData
);

    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred for the unused encoding.
    always_comb begin
        writeData = aluResult;
        case (sel)
            SrcMem:  writeData = memData;
            SrcPc:   writeData = pcPlus4;
            default: writeData = aluResult;
        endcase
    end

endmodule : wb_source_mux

// File: rtl/mem_wb_writeback.sv
// ----------------------------------------------------------------------------
// mem_wb_writeback
//
// MEM/WB pipeline register plus write-back selection. Latches the MEM-stage
// result, selects write data (ALU result, load data or PC+4 for link), forces
// the link destination, and drives the register-file write port with a
// same-cycle hit indication back to decode. Also counts retired instructions.
//
// Optional feature: define WB_BYPASS_EN to add id_ReadData1/2 inputs and
// id_FwdData1/2 outputs that forward the write-back value to decode when the
// indices match.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   stall, flush          hold / squash the MEM/WB register (flush wins)
//   mem_*                 MEM-stage instruction fields
//   id_ReadRegister1/2    decode source indices for the hit compare
//   wb_RegWrite           register-file write enable
//   wb_WriteRegister      register-file write index
//   wb_WriteData          register-file write data
//   wb_Hit1/2             write-back targets decode index 1/2 this cycle
//   wb_RetireCount        instructions retired since reset (wraps)
// ----------------------------------------------------------------------------
import mem_wb_writeback_pkg::*;

module mem_wb_writeback #(
    parameter int NBits       = 32,
    parameter int RegAddrBits = DefRegAddrBits,
    parameter int LinkReg     = DefLinkReg,
    parameter int CntBits     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   mem_valid,
    input  logic                   mem_RegWrite,
    input  logic                   mem_MemtoReg,
    input  logic                   mem_ALUMemOrPC,
    input  logic [RegAddrBits-1:0] mem_WriteRegister,
    input  logic [NBits-1:0]       mem_ALUResult,
    input  logic [NBits-1:0]       mem_ReadData,
    input  logic [NBits-1:0]       mem_PCPlus4,
    input  logic [RegAddrBits-1:0] id_ReadRegister1,
    input  logic [RegAddrBits-1:0] id_ReadRegister2,
`ifdef WB_BYPASS_EN
    input  logic [NBits-1:0]       id_ReadData1,
    input  logic [NBits-1:0]       id_ReadData2,
    output logic [NBits-1:0]       id_FwdData1,
    output logic [NBits-1:0]       id_FwdData2,
`endif
    output logic                   wb_RegWrite,
    output logic [RegAddrBits-1:0] wb_WriteRegister,
    output logic [NBits-1:0]       wb_WriteData,
    output logic                   wb_Hit1,
    output logic                   wb_Hit2,
    output logic [CntBits-1:0]     wb_RetireCount
);

    logic                   validQ;
    logic                   regWriteQ;
    logic                   memtoRegQ;
    logic                   aluMemOrPcQ;
    logic [RegAddrBits-1:0] writeRegisterQ;
    logic [NBits-1:0]       aluResultQ;
    logic [NBits-1:0]       readDataQ;
    logic [NBits-1:0]       pcPlus4Q;
    logic [CntBits-1:0]     retireCountQ;

    // The instruction currently in WB leaves on this edge unless it is held.
    logic retiring;
    assign retiring = validQ & (~stall | flush);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            validQ         <= 1'b0;
            regWriteQ      <= 1'b0;
            memtoRegQ      <= 1'b0;
            aluMemOrPcQ    <= 1'b0;
            writeRegisterQ <= '0;
            aluResultQ     <= '0;
            readDataQ      <= '0;
            pcPlus4Q       <= '0;
            retireCountQ   <= '0;
        end else begin
            if (retiring) begin
                retireCountQ <= retireCountQ + CntBits'(1);
            end

            if (flush) begin
                validQ         <= 1'b0;
                regWriteQ      <= 1'b0;
                memtoRegQ      <= 1'b0;
                aluMemOrPcQ    <= 1'b0;
                writeRegisterQ <= '0;
                aluResultQ     <= '0;
                readDataQ      <= '0;
                pcPlus4Q       <= '0;
            end else if (!stall) begin
                validQ         <= mem_valid;
                regWriteQ      <= mem_RegWrite;
                memtoRegQ      <= mem_MemtoReg;
                aluMemOrPcQ    <= mem_ALUMemOrPC;
                writeRegisterQ <= mem_WriteRegister;
                aluResultQ     <= mem_ALUResult;
                readDataQ      <= mem_ReadData;
                pcPlus4Q       <= mem_PCPlus4;
            end
        end
    end

    // Link takes precedence over load selection.
    wbSrc_e wbSrc;
    assign wbSrc = aluMemOrPcQ ? SrcPc : (memtoRegQ ? SrcMem : SrcAlu);

    wb_source_mux #(
        .NBits(NBits)
    ) u_wb_source_mux (
        .sel       (wbSrc),
        .aluResult (aluResultQ),
        .memData   (readDataQ),
        .pcPlus4   (pcPlus4Q),
        .writeData (wb_WriteData)
    );

    assign wb_WriteRegister = aluMemOrPcQ ? RegAddrBits'(LinkReg) : writeRegisterQ;

    // Link instructions write even without RegWrite; $0 is never written.
    assign wb_RegWrite = validQ & (regWriteQ | aluMemOrPcQ)
                       & (wb_WriteRegister != RegAddrBits'(ZeroReg));

    assign wb_Hit1 = wb_RegWrite & (wb_WriteRegister == id_ReadRegister1);
    assign wb_Hit2 = wb_RegWrite & (wb_WriteRegister == id_ReadRegister2);

    assign wb_RetireCount = retireCountQ;

`ifdef WB_BYPASS_EN
    assign id_FwdData1 = wb_Hit1 ? wb_WriteData : id_ReadData1;
    assign id_FwdData2 = wb_Hit2 ? wb_WriteData : id_ReadData2;
`endif

endmodule : mem_wb_writeback

// File: tb/tb_mem_wb_writeback.sv
// ----------------------------------------------------------------------------
// tb_mem_wb_writeback
//
// Directed self-checking bench for mem_wb_writeback. Inputs change just after
// a rising edge; outputs are sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_wb_writeback;

    localparam int NBits       = 32;
    localparam int RegAddrBits = 5;
    localparam int CntBits     = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   stall;
    logic                   flush;
    logic                   mem_valid;
    logic                   mem_RegWrite;
    logic                   mem_MemtoReg;
    logic                   mem_ALUMemOrPC;
    logic [RegAddrBits-1:0] mem_WriteRegister;
    logic [NBits-1:0]       mem_ALUResult;
    logic [NBits-1:0]       mem_ReadData;
    logic [NBits-1:0]       mem_PCPlus4;
    logic [RegAddrBits-1:0] id_ReadRegister1;
    logic [RegAddrBits-1:0] id_ReadRegister2;
`ifdef WB_BYPASS_EN
    logic [NBits-1:0]       id_ReadData1;
    logic [NBits-1:0]       id_ReadData2;
    logic [NBits-1:0]       id_FwdData1;
    logic [NBits-1:0]       id_FwdData2;
`endif
    logic                   wb_RegWrite;
    logic [RegAddrBits-1:0] wb_WriteRegister;
    logic [NBits-1:0]       wb_WriteData;
    logic                   wb_Hit1;
    logic                   wb_Hit2;
    logic [CntBits-1:0]     wb_RetireCount;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    mem_wb_writeback #(
        .NBits       (NBits),
        .RegAddrBits (RegAddrBits),
        .LinkReg     (31),
        .CntBits     (CntBits)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .mem_valid         (mem_valid),
        .mem_RegWrite      (mem_RegWrite),
        .mem_MemtoReg      (mem_MemtoReg),
        .mem_ALUMemOrPC    (mem_ALUMemOrPC),
        .mem_WriteRegister (mem_WriteRegister),
        .mem_ALUResult     (mem_ALUResult),
        .mem_ReadData      (mem_ReadData),
        .mem_PCPlus4       (mem_PCPlus4),
        .id_ReadRegister1  (id_ReadRegister1),
        .id_ReadRegister2  (id_ReadRegister2),
`ifdef WB_BYPASS_EN
        .id_ReadData1      (id_ReadData1),
        .id_ReadData2      (id_ReadData2),
        .id_FwdData1       (id_FwdData1),
        .id_FwdData2       (id_FwdData2),
`endif
        .wb_RegWrite       (wb_RegWrite),
        .wb_WriteRegister  (wb_WriteRegister),
        .wb_WriteData      (wb_WriteData),
        .wb_Hit1           (wb_Hit1),
        .wb_Hit2           (wb_Hit2),
        .wb_RetireCount    (wb_RetireCount)
    );

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setInstr(input logic v, input logic rw, input logic m2r,
                            input logic link, input logic [RegAddrBits-1:0] wr,
                            input logic [NBits-1:0] alu, input logic [NBits-1:0] rd,
                            input logic [NBits-1:0] pc4);
        mem_valid         = v;
        mem_RegWrite      = rw;
        mem_MemtoReg      = m2r;
        mem_ALUMemOrPC    = link;
        mem_WriteRegister = wr;
        mem_ALUResult     = alu;
        mem_ReadData      = rd;
        mem_PCPlus4       = pc4;
    endtask

    task automatic checkPort(input string tag, input logic we,
                             input logic [RegAddrBits-1:0] wr,
                             input logic [NBits-1:0] wd, input logic [CntBits-1:0] cnt);
        check({tag, ".RegWrite"},      64'(wb_RegWrite),      64'(we));
        check({tag, ".WriteRegister"}, 64'(wb_WriteRegister), 64'(wr));
        check({tag, ".WriteData"},     64'(wb_WriteData),     64'(wd));
        check({tag, ".RetireCount"},   64'(wb_RetireCount),   64'(cnt));
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        setInstr(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h1111, 32'h2222, 32'h3333);
        id_ReadRegister1 = '0;
        id_ReadRegister2 = '0;
`ifdef WB_BYPASS_EN
        id_ReadData1 = '0;
        id_ReadData2 = '0;
`endif
        tick();
        tick();

        // Reset state: everything zero even with a valid instruction presented.
        checkPort("reset", 1'b0, 5'd0, 32'h0, 32'd0);
        check("reset.Hit1", 64'(wb_Hit1), 64'd0);
        check("reset.Hit2", 64'(wb_Hit2), 64'd0);

        // R-type to $8.
        reset = 1'b0;
        setInstr(1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_0010, 32'h0, 32'h0);
        tick();
        checkPort("rtype", 1'b1, 5'd8, 32'h10, 32'd0);

        // Load to $9: load data wins over ALU result; R-type retires.
        setInstr(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h1000_0000, 32'hDEAD_BEEF, 32'h0);
        tick();
        checkPort("load", 1'b1, 5'd9, 32'hDEAD_BEEF, 32'd1);

        // JAL: link forces $31 and PC+4 even with RegWrite=0 and WriteRegister=0.
        setInstr(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'hAAAA_0000, 32'hBBBB_0000, 32'h0040_0008);
        id_ReadRegister1 = 5'd31;
        tick();
        checkPort("jal", 1'b1, 5'd31, 32'h0040_0008, 32'd2);
        check("jal.Hit1", 64'(wb_Hit1), 64'd1);

        // Write to $0 is suppressed, no hit on index 0.
        setInstr(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_1234, 32'h0, 32'h0);
        id_ReadRegister1 = 5'd0;
        tick();
        checkPort("zero", 1'b0, 5'd0, 32'h1234, 32'd3);
        check("zero.Hit1", 64'(wb_Hit1), 64'd0);

        // Bubble: the $0 instruction still counts as retired.
        setInstr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        checkPort("bubble", 1'b0, 5'd0, 32'h0, 32'd4);

        // Instruction A to $5, then stall three cycles with new inputs presented.
        setInstr(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_00A5, 32'h0, 32'h0);
        tick();
        checkPort("instrA", 1'b1, 5'd5, 32'hA5, 32'd4);
        setInstr(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0000_00FF, 32'h0, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkPort($sformatf("stall%0d", i), 1'b1, 5'd5, 32'hA5, 32'd4);
        end

        // Flush beats stall: A retires, WB goes invalid.
        flush = 1'b1;
        tick();
        checkPort("flushStall", 1'b0, 5'd0, 32'h0, 32'd5);

        // Stall with nothing valid: counter holds, no write.
        flush = 1'b0;
        tick();
        checkPort("stallIdle", 1'b0, 5'd0, 32'h0, 32'd5);

        // Bypass: WB writes $12=0x55 while decode reads $12 on port 2.
        stall = 1'b0;
        setInstr(1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0055, 32'h0, 32'h0);
        id_ReadRegister1 = 5'd4;
        id_ReadRegister2 = 5'd12;
`ifdef WB_BYPASS_EN
        id_ReadData1 = 32'h0000_0077;
        id_ReadData2 = 32'h0;
`endif
        tick();
        checkPort("bypass", 1'b1, 5'd12, 32'h55, 32'd5);
        check("bypass.Hit1", 64'(wb_Hit1), 64'd0);
        check("bypass.Hit2", 64'(wb_Hit2), 64'd1);
`ifdef WB_BYPASS_EN
        check("bypass.Fwd1", 64'(id_FwdData1), 64'h77);
        check("bypass.Fwd2", 64'(id_FwdData2), 64'h55);
`endif

        // Reset asserted mid-stall clears everything on that edge.
        stall = 1'b1;
        reset = 1'b1;
        tick();
        checkPort("midReset", 1'b0, 5'd0, 32'h0, 32'd0);
        check("midReset.Hit2", 64'(wb_Hit2), 64'd0);

        reset = 1'b0;
        stall = 1'b0;
        setInstr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        checkPort("postReset", 1'b0, 5'd0, 32'h0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule : tb_mem_wb_writeback
